// File: rtl/reflet_cpu_core.sv
`default_nettype none
// ============================================================================
//  Module   : reflet_cpu_core
//  Purpose  : Multi-cycle accumulator CPU for the Reflet ISA. Instructions are
//             8 bits wide and the datapath is 'wordsize' bits wide. Code and
//             data share one memory port. Memory reads return data one cycle
//             after the address is presented.
//  Ports    : clk      - clock; all state changes on the rising edge
//             reset    - asynchronous active-high reset; clears all state
//             quit     - high while halted by the quit instruction
//             data_in  - memory read data, valid one cycle after addr
//             addr     - memory word address
//             data_out - memory write data
//             write_en - memory write strobe, one cycle per write
//             ext_int  - level-sensitive external interrupt requests
//  Revision : 1.0 - initial release
// ============================================================================
module reflet_cpu_core #(
    parameter int wordsize = 16
) (
    input  logic                clk,
    input  logic                reset,
    output logic                quit,
    input  logic [wordsize-1:0] data_in,
    output logic [wordsize-1:0] addr,
    output logic [wordsize-1:0] data_out,
    output logic                write_en,
    input  logic [3:0]          ext_int
);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_MEM_WR = 3'd2;
    localparam logic [2:0] ST_MEM_RD = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam int WR = 0;
    localparam int SR = 13;
    localparam int SP = 14;
    localparam int PC = 15;

    localparam logic [wordsize-1:0] WORD_ONE = {{(wordsize-1){1'b0}}, 1'b1};

    logic [2:0]          state;
    logic [2:0]          next_state;
    logic [wordsize-1:0] regs [16];
    logic [wordsize-1:0] mem_addr;     // target address of the pending memory access
    logic [wordsize-1:0] mem_data;     // data of the pending write
    logic                load_to_pc;   // pending read lands in PC (ret) instead of WR

    logic [wordsize-1:0] wr;
    logic [wordsize-1:0] sp;
    logic [wordsize-1:0] pc;
    logic [wordsize-1:0] rx;
    logic [3:0]          opc;
    logic [3:0]          rx_idx;
    logic                cmp;
    logic                in_int;
    logic [3:0]          irq_pending;
    logic                irq_take;
    logic [wordsize-1:0] irq_vector;

    assign wr          = regs[WR];
    assign sp          = regs[SP];
    assign pc          = regs[PC];
    assign opc         = data_in[7:4];
    assign rx_idx      = data_in[3:0];
    assign rx          = regs[rx_idx];
    assign cmp         = regs[SR][0];
    assign in_int      = regs[SR][1];
    assign irq_pending = ext_int & regs[SR][7:4];
    assign irq_take    = !in_int && (irq_pending != 4'b0000);

    // Lowest-numbered enabled request wins; vector for line i is 4*(i+1).
    always_comb begin
        irq_vector = '0;
        if (irq_pending[0])      irq_vector = wordsize'(4);
        else if (irq_pending[1]) irq_vector = wordsize'(8);
        else if (irq_pending[2]) irq_vector = wordsize'(12);
        else if (irq_pending[3]) irq_vector = wordsize'(16);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            ST_FETCH: begin
                // An accepted interrupt replaces the fetch with a push cycle.
                next_state = irq_take ? ST_MEM_WR : ST_DECODE;
            end
            ST_DECODE: begin
                next_state = ST_FETCH;
                if (opc == 4'hE) begin
                    next_state = ST_MEM_WR;
                end else if (opc == 4'hF) begin
                    next_state = ST_MEM_RD;
                end else if (opc == 4'h0) begin
                    case (rx_idx)
                        4'h3, 4'h6, 4'h9: next_state = ST_MEM_RD;
                        4'h4, 4'h5:       next_state = ST_MEM_WR;
                        4'h7:             next_state = ST_HALT;
                        default:          next_state = ST_FETCH;
                    endcase
                end
            end
            ST_MEM_WR: next_state = ST_FETCH;
            ST_MEM_RD: next_state = ST_WAIT;
            ST_WAIT:   next_state = ST_FETCH;
            ST_HALT:   next_state = ST_HALT;
            default:   next_state = ST_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: bus signals are decoded from the current state so an
    // asynchronous reset withdraws a pending write immediately.
    // ------------------------------------------------------------------
    always_comb begin
        quit     = (state == ST_HALT);
        write_en = (state == ST_MEM_WR);
        addr     = pc;
        data_out = '0;
        if (state == ST_MEM_WR || state == ST_MEM_RD) begin
            addr = mem_addr;
        end
        if (state == ST_MEM_WR) begin
            data_out = mem_data;
        end
    end

    // ------------------------------------------------------------------
    // Datapath / register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
            mem_addr   <= '0;
            mem_data   <= '0;
            load_to_pc <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (irq_take) begin
                        regs[SP]    <= sp - WORD_ONE;
                        mem_addr    <= sp - WORD_ONE;
                        mem_data    <= pc;
                        regs[PC]    <= irq_vector;
                        regs[SR][1] <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    // Default sequential advance; PC-writing instructions
                    // below override it (later non-blocking write wins).
                    regs[PC] <= pc + WORD_ONE;
                    case (opc)
                        4'h1: regs[WR] <= {{(wordsize-4){1'b0}}, rx_idx};
                        4'h2: regs[WR] <= rx;
                        4'h3: regs[rx_idx] <= wr;
                        4'h4: regs[WR] <= wr + rx;
                        4'h5: regs[WR] <= wr - rx;
                        4'h6: regs[WR] <= wr & rx;
                        4'h7: regs[WR] <= wr | rx;
                        4'h8: regs[WR] <= wr ^ rx;
                        4'h9: regs[WR] <= ~rx;
                        // Logical shifts by >= wordsize naturally yield zero.
                        4'hA: regs[WR] <= wr << rx;
                        4'hB: regs[WR] <= wr >> rx;
                        4'hC: regs[SR][0] <= (wr == rx);
                        4'hD: regs[SR][0] <= (wr < rx);
                        4'hE: begin
                            mem_addr <= rx;
                            mem_data <= wr;
                        end
                        4'hF: begin
                            mem_addr   <= rx;
                            load_to_pc <= 1'b0;
                        end
                        default: begin
                            case (rx_idx)
                                4'h1: regs[SR][0] <= ~cmp;
                                4'h2: begin
                                    if (cmp) begin
                                        regs[PC] <= wr;
                                    end
                                end
                                4'h3: begin
                                    mem_addr   <= sp;
                                    regs[SP]   <= sp + WORD_ONE;
                                    load_to_pc <= 1'b0;
                                end
                                4'h4: begin
                                    regs[SP] <= sp - WORD_ONE;
                                    mem_addr <= sp - WORD_ONE;
                                    mem_data <= wr;
                                end
                                4'h5: begin
                                    regs[SP] <= sp - WORD_ONE;
                                    mem_addr <= sp - WORD_ONE;
                                    mem_data <= pc + WORD_ONE;
                                    regs[PC] <= wr;
                                end
                                4'h6: begin
                                    mem_addr   <= sp;
                                    regs[SP]   <= sp + WORD_ONE;
                                    load_to_pc <= 1'b1;
                                end
                                4'h8: regs[SR][7:4] <= wr[3:0];
                                4'h9: begin
                                    mem_addr    <= sp;
                                    regs[SP]    <= sp + WORD_ONE;
                                    load_to_pc  <= 1'b1;
                                    regs[SR][1] <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    endcase
                end
                ST_WAIT: begin
                    if (load_to_pc) begin
                        regs[PC] <= data_in;
                    end else begin
                        regs[WR] <= data_in;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reflet_cpu_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_reflet_cpu_core
//  Purpose  : Self-checking bench for reflet_cpu_core (wordsize 8). Each test
//             loads a small program into a behavioural memory, runs it to the
//             quit instruction, and compares register and bus results against
//             hand-derived values. Memory writes are checked by a scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reflet_cpu_core;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] d;
    } wr_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         quit;
    logic [W-1:0] data_in;
    logic [W-1:0] addr;
    logic [W-1:0] data_out;
    logic         write_en;
    logic [3:0]   ext_int = 4'h0;

    logic [W-1:0] mem [256];
    logic         ld_en = 1'b0;
    logic [7:0]   ld_addr = 8'h00;
    logic [W-1:0] ld_data = '0;

    int  n_checks = 0;
    int  n_fail = 0;
    wr_t exp_q[$];
    wr_t got;

    always #5 clk = ~clk;

    reflet_cpu_core #(.wordsize(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .quit     (quit),
        .data_in  (data_in),
        .addr     (addr),
        .data_out (data_out),
        .write_en (write_en),
        .ext_int  (ext_int)
    );

    // Behavioural memory: one-cycle read latency, bench loading port.
    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (write_en) begin
            mem[addr] <= data_out;
        end
        data_in <= mem[addr];
    end

    // Write scoreboard
    always @(negedge clk) begin
        if (!reset && write_en === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: addr=%02h data=%02h, required no write", addr, data_out);
            end else begin
                got = exp_q.pop_front();
                if (addr !== got.a || data_out !== got.d) begin
                    n_fail++;
                    $display("FAIL write_value: addr=%02h data=%02h, required addr=%02h data=%02h",
                             addr, data_out, got.a, got.d);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] hexval(input byte c);
        if (c >= 8'h30 && c <= 8'h39) return 4'(c - 8'h30);
        if (c >= 8'h41 && c <= 8'h46) return 4'(c - 8'h37);
        return 4'h0;
    endfunction

    // Holds the core in reset and writes a program image "HH HH ..." at 0,
    // zero-filling the rest of memory.
    task automatic load_prog(input string s);
        int nbytes;
        nbytes = (s.len() + 1) / 3;
        reset = 1'b1;
        ext_int = 4'h0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = 8'(i);
            if (i < nbytes) begin
                ld_data = {hexval(s.getc(3*i)), hexval(s.getc(3*i+1))};
            end else begin
                ld_data = '0;
            end
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Releases reset and counts rising edges until quit or budget.
    task automatic run_prog(input int budget, output int cycles);
        @(negedge clk);
        reset = 1'b0;
        cycles = 0;
        while (quit !== 1'b1 && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (quit !== 1'b0) begin n_fail++; $display("FAIL reset_quit: got %b, required 0", quit); end
        n_checks++;
        if (write_en !== 1'b0) begin n_fail++; $display("FAIL reset_write_en: got %b, required 0", write_en); end
        n_checks++;
        if (addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %02h, required 00", addr); end
        n_checks++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %02h, required 00", data_out); end
    endtask

    task automatic test_alu_basic();
        int         cyc;
        int         ridx [3] = '{0, 1, 15};
        logic [7:0] rexp [3] = '{8'h08, 8'h05, 8'h05};
        load_prog("15 31 13 41 07");
        run_prog(40, cyc);
        n_checks++;
        if (quit !== 1'b1 || cyc != 10) begin
            n_fail++;
            $display("FAIL basic_quit_cycles: quit=%b after %0d cycles, required quit=1 after 10", quit, cyc);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (dut.regs[ridx[i]] !== rexp[i]) begin
                n_fail++;
                $display("FAIL basic_R%0d: got %02h, required %02h", ridx[i], dut.regs[ridx[i]], rexp[i]);
            end
        end
        // Halt is sticky and ignores interrupt lines.
        ext_int = 4'hF;
        repeat (6) @(negedge clk);
        n_checks++;
        if (quit !== 1'b1 || write_en !== 1'b0 || dut.regs[15] !== 8'h05) begin
            n_fail++;
            $display("FAIL halt_frozen: quit=%b write_en=%b pc=%02h, required quit=1 write_en=0 pc=05",
                     quit, write_en, dut.regs[15]);
        end
        ext_int = 4'h0;
    endtask

    task automatic test_push_pop();
        int cyc;
        load_prog("1F 3E 12 04 11 03 07");
        exp_q.push_back('{a: 8'h0E, d: 8'h02});
        run_prog(60, cyc);
        n_checks++;
        if (quit !== 1'b1) begin n_fail++; $display("FAIL pushpop_timeout: quit=%b, required 1", quit); end
        n_checks++;
        if (dut.regs[0] !== 8'h02) begin n_fail++; $display("FAIL pushpop_WR: got %02h, required 02", dut.regs[0]); end
        n_checks++;
        if (dut.regs[14] !== 8'h0F) begin n_fail++; $display("FAIL pushpop_SP: got %02h, required 0F", dut.regs[14]); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL pushpop_writes: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_branch();
        int cyc;
        // cmp true: jif jumps to WR=6
        load_prog("16 31 C1 02 17 07 32 07");
        run_prog(60, cyc);
        n_checks++;
        if (quit !== 1'b1 || dut.regs[2] !== 8'h06 || dut.regs[15] !== 8'h08) begin
            n_fail++;
            $display("FAIL jif_taken: quit=%b R2=%02h pc=%02h, required quit=1 R2=06 pc=08",
                     quit, dut.regs[2], dut.regs[15]);
        end
        // eq false, les true, cc2 inverts, jif falls through
        load_prog("16 31 15 C1 D1 01 02 32 07");
        run_prog(60, cyc);
        n_checks++;
        if (quit !== 1'b1 || dut.regs[2] !== 8'h05 || dut.regs[15] !== 8'h09) begin
            n_fail++;
            $display("FAIL jif_fall: quit=%b R2=%02h pc=%02h, required quit=1 R2=05 pc=09",
                     quit, dut.regs[2], dut.regs[15]);
        end
        n_checks++;
        if (dut.regs[13] !== 8'h00) begin n_fail++; $display("FAIL cmp_flag: SR=%02h, required 00", dut.regs[13]); end
    endtask

    task automatic test_alu_ops();
        int         cyc;
        int         ridx [10] = '{2, 3, 4, 6, 7, 8, 9, 10, 12, 0};
        logic [7:0] rexp [10] = '{8'h08, 8'h0E, 8'h06, 8'h08, 8'h01, 8'hF4, 8'h00, 8'hF9, 8'h11, 8'h00};
        load_prog({"1C 31 1A 61 32 1A 71 33 1A 81 34 13 35 11 A5 36 1F B5 37 10 ",
                   "51 38 1F A6 39 94 3A 11 3B 1F 4B 4B 3C 10 90 4B 07"});
        run_prog(120, cyc);
        n_checks++;
        if (quit !== 1'b1) begin n_fail++; $display("FAIL alu_timeout: quit=%b, required 1", quit); end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (dut.regs[ridx[i]] !== rexp[i]) begin
                n_fail++;
                $display("FAIL alu_R%0d: got %02h, required %02h", ridx[i], dut.regs[ridx[i]], rexp[i]);
            end
        end
    endtask

    task automatic test_load_store();
        int cyc;
        load_prog("1E 33 17 E3 1D 34 10 F4 35 F3 07 00 00 5A");
        exp_q.push_back('{a: 8'h0E, d: 8'h07});
        run_prog(80, cyc);
        n_checks++;
        if (quit !== 1'b1 || dut.regs[5] !== 8'h5A || dut.regs[0] !== 8'h07) begin
            n_fail++;
            $display("FAIL load_store: quit=%b R5=%02h WR=%02h, required quit=1 R5=5A WR=07",
                     quit, dut.regs[5], dut.regs[0]);
        end
        n_checks++;
        if (mem[14] !== 8'h07) begin n_fail++; $display("FAIL store_mem: mem[0E]=%02h, required 07", mem[14]); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL store_writes: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_call_ret();
        int cyc;
        load_prog("16 05 32 07 00 00 19 06");
        exp_q.push_back('{a: 8'hFF, d: 8'h02});
        run_prog(60, cyc);
        n_checks++;
        if (quit !== 1'b1 || dut.regs[2] !== 8'h09 || dut.regs[14] !== 8'h00 || dut.regs[15] !== 8'h04) begin
            n_fail++;
            $display("FAIL call_ret: quit=%b R2=%02h SP=%02h pc=%02h, required quit=1 R2=09 SP=00 pc=04",
                     quit, dut.regs[2], dut.regs[14], dut.regs[15]);
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL call_writes: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_interrupt();
        int cyc;
        // Line 0 held high throughout; handler disables IE then retint.
        load_prog("11 08 3B 07 19 3C 10 08 09");
        exp_q.push_back('{a: 8'hFF, d: 8'h02});
        ext_int = 4'h1;
        run_prog(80, cyc);
        n_checks++;
        if (quit !== 1'b1 || dut.regs[12] !== 8'h09 || dut.regs[11] !== 8'h00) begin
            n_fail++;
            $display("FAIL int_taken: quit=%b R12=%02h R11=%02h, required quit=1 R12=09 R11=00",
                     quit, dut.regs[12], dut.regs[11]);
        end
        n_checks++;
        if (dut.regs[13] !== 8'h00 || dut.regs[14] !== 8'h00 || dut.regs[15] !== 8'h04) begin
            n_fail++;
            $display("FAIL int_return: SR=%02h SP=%02h pc=%02h, required SR=00 SP=00 pc=04",
                     dut.regs[13], dut.regs[14], dut.regs[15]);
        end
        // Lines 1 and 2 both requested: line 1 (vector 8) must win.
        load_prog("1F 08 07 00 07 00 00 00 17 3C 10 08 09");
        exp_q.push_back('{a: 8'hFF, d: 8'h02});
        ext_int = 4'b0110;
        run_prog(80, cyc);
        n_checks++;
        if (quit !== 1'b1 || dut.regs[12] !== 8'h07 || dut.regs[15] !== 8'h03) begin
            n_fail++;
            $display("FAIL int_priority: quit=%b R12=%02h pc=%02h, required quit=1 R12=07 pc=03",
                     quit, dut.regs[12], dut.regs[15]);
        end
        ext_int = 4'h0;
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL int_writes: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_store();
        int cyc;
        bit seen;
        load_prog("1E 33 17 E3 07");
        exp_q.push_back('{a: 8'h0E, d: 8'h07});   // aborted attempt, still presented
        exp_q.push_back('{a: 8'h0E, d: 8'h07});   // re-executed after restart
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = (write_en === 1'b1);
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL abort_no_store: write_en=%b, required a store cycle", write_en); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (write_en !== 1'b0 || addr !== 8'h00 || quit !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: write_en=%b addr=%02h quit=%b, required 0 00 0", write_en, addr, quit);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (addr !== 8'h00 || write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_next_cycle: addr=%02h write_en=%b, required 00 0", addr, write_en);
        end
        n_checks++;
        if (mem[14] !== 8'h00) begin n_fail++; $display("FAIL abort_suppressed: mem[0E]=%02h, required 00", mem[14]); end
        run_prog(40, cyc);
        n_checks++;
        if (quit !== 1'b1 || mem[14] !== 8'h07) begin
            n_fail++;
            $display("FAIL abort_restart: quit=%b mem[0E]=%02h, required quit=1 mem[0E]=07", quit, mem[14]);
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL abort_writes: %0d pending, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_push_pop();
        test_branch();
        test_alu_ops();
        test_load_store();
        test_call_ret();
        test_interrupt();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
